// File: rtl/ws_psum_accum.sv
// ws_psum_accum: accumulates Q3.6 PE-column partial sums over channel passes; ReLU/saturate and stream Q3.6 results on the final pass
// Ports: sys_clk_i/sys_rst_i clock and async active-high reset; start_i/relu_en_i begin a tile;
//        in_valid_i/in_data_i/in_ready_o psum input handshake; out_valid_o/out_data_o/out_ready_i result handshake;
//        busy_o high while a tile is in progress; done_o pulses once after the last result is accepted
module ws_psum_accum #(
  parameter int DEPTH  = 16,
  parameter int PASSES = 4,
  parameter int ACC_W  = 16
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              start_i,
  input  logic              relu_en_i,
  input  logic              in_valid_i,
  input  logic signed [9:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic signed [9:0] out_data_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              done_o
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int PW = PASSES > 1 ? $clog2(PASSES) : 1;
  localparam logic signed [ACC_W-1:0] MAXV = 511;
  localparam logic signed [ACC_W-1:0] MINV = -512;
  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [PW-1:0] pass_q;
  logic relu_q, out_valid_q, done_q;
  logic signed [9:0] out_data_q, sat;
  logic signed [ACC_W-1:0] mem_q [DEPTH];
  logic signed [ACC_W-1:0] ext, prev, sum, rect;
  logic final_pass, last_addr, in_fire, out_fire;
  assign final_pass = pass_q == PW'(PASSES - 1);
  assign last_addr = addr_q == AW'(DEPTH - 1);
  // On the final pass the single output register must have room, or be emptying this cycle
  assign in_ready_o = state_q == ACCUM && (!final_pass || !out_valid_q || out_ready_i);
  assign in_fire = in_valid_i && in_ready_o;
  assign out_fire = out_valid_q && out_ready_i;
  assign ext = {{(ACC_W-10){in_data_i[9]}}, in_data_i};
  // Pass 0 ignores stale buffer contents, so the buffer never needs clearing
  assign prev = pass_q == '0 ? '0 : mem_q[addr_q];
  assign sum = prev + ext;
  assign rect = relu_q && sum[ACC_W-1] ? '0 : sum;
  assign sat = rect > MAXV ? 10'sd511 : rect < MINV ? -10'sd512 : rect[9:0];
  assign out_valid_o = out_valid_q;
  assign out_data_o = out_data_q;
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start_i ? ACCUM : IDLE;
      ACCUM:   state_d = in_fire && final_pass && last_addr ? FLUSH : ACCUM;
      FLUSH:   state_d = out_fire ? IDLE : FLUSH;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk_i) begin
    if (in_fire && !final_pass) mem_q[addr_q] <= sum;
  end
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q <= IDLE;
      addr_q <= '0;
      pass_q <= '0;
      relu_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q <= state_q == FLUSH && out_fire;
      if (state_q == IDLE && start_i) begin
        addr_q <= '0;
        pass_q <= '0;
        relu_q <= relu_en_i;
      end else if (in_fire) begin
        addr_q <= last_addr ? '0 : addr_q + 1'b1;
        if (last_addr) pass_q <= final_pass ? '0 : pass_q + 1'b1;
      end
      if (in_fire && final_pass) begin
        out_valid_q <= 1'b1;
        out_data_q <= sat;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ws_psum_accum.sv
// tb_ws_psum_accum: directed scoreboard bench for ws_psum_accum (4x3 and 2x1 configurations)
module tb_ws_psum_accum;
  logic clk = 1'b0;
  logic rst;
  logic a_start, a_relu, a_iv, a_ir, a_ov, a_or, a_busy, a_done;
  logic signed [9:0] a_id, a_od;
  logic b_start, b_relu, b_iv, b_ir, b_ov, b_or, b_busy, b_done;
  logic signed [9:0] b_id, b_od;
  int total = 0;
  int bad = 0;
  int qa[$];
  int qb[$];
  int v[3][4];
  int e[4];
  always #5 clk = ~clk;
  ws_psum_accum #(.DEPTH(4), .PASSES(3), .ACC_W(16)) dut_a (
    .sys_clk_i(clk), .sys_rst_i(rst), .start_i(a_start), .relu_en_i(a_relu),
    .in_valid_i(a_iv), .in_data_i(a_id), .in_ready_o(a_ir),
    .out_valid_o(a_ov), .out_data_o(a_od), .out_ready_i(a_or),
    .busy_o(a_busy), .done_o(a_done));
  ws_psum_accum #(.DEPTH(2), .PASSES(1), .ACC_W(16)) dut_b (
    .sys_clk_i(clk), .sys_rst_i(rst), .start_i(b_start), .relu_en_i(b_relu),
    .in_valid_i(b_iv), .in_data_i(b_id), .in_ready_o(b_ir),
    .out_valid_o(b_ov), .out_data_o(b_od), .out_ready_i(b_or),
    .busy_o(b_busy), .done_o(b_done));
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (a_ov && a_or) begin
      if (qa.size() == 0) chk("a_unexpected_out", a_od, 9999);
      else chk("a_out", a_od, qa.pop_front());
    end
    if (b_ov && b_or) begin
      if (qb.size() == 0) chk("b_unexpected_out", b_od, 9999);
      else chk("b_out", b_od, qb.pop_front());
    end
  end
  task automatic send(input bit s, input int d);
    int t = 0;
    if (s) begin b_iv = 1'b1; b_id = d[9:0]; end
    else begin a_iv = 1'b1; a_id = d[9:0]; end
    @(negedge clk);
    while (!(s ? b_ir : a_ir) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    a_iv = 1'b0;
    b_iv = 1'b0;
  endtask
  task automatic pulse_start(input bit s, input bit relu);
    if (s) begin b_start = 1'b1; b_relu = relu; end
    else begin a_start = 1'b1; a_relu = relu; end
    @(posedge clk); #1;
    a_start = 1'b0;
    b_start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", s ? b_busy : a_busy, 1);
    chk("in_ready_after_start", s ? b_ir : a_ir, 1);
    @(posedge clk); #1;
  endtask
  task automatic wait_done(input bit s);
    int t = 0;
    @(negedge clk);
    while (!(s ? b_done : a_done) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", s ? b_done : a_done, 1);
    chk("busy_at_done", s ? b_busy : a_busy, 0);
    @(negedge clk);
    chk("done_one_pulse", s ? b_done : a_done, 0);
    @(posedge clk); #1;
  endtask
  task automatic send_pass(input int p);
    for (int i = 0; i < 4; i++) send(0, v[p][i]);
  endtask
  task automatic run_a(input bit relu);
    pulse_start(0, relu);
    send_pass(0);
    send_pass(1);
    for (int i = 0; i < 4; i++) qa.push_back(e[i]);
    send_pass(2);
    wait_done(0);
  endtask
  task automatic chk_reset_vals(input string nm);
    chk({nm, "_in_ready"}, a_ir, 0);
    chk({nm, "_out_valid"}, a_ov, 0);
    chk({nm, "_out_data"}, a_od, 0);
    chk({nm, "_busy"}, a_busy, 0);
    chk({nm, "_done"}, a_done, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    {a_start, a_relu, a_iv, b_start, b_relu, b_iv} = '0;
    a_id = '0;
    b_id = '0;
    a_or = 1'b1;
    b_or = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    // 1.0 in every pass -> 3.0
    v = '{'{64, 64, 64, 64}, '{64, 64, 64, 64}, '{64, 64, 64, 64}};
    e = '{192, 192, 192, 192};
    run_a(0);
    // -1.5 + 0.5 + 0 = -1.0, with other mixed pixels, relu off then on
    v = '{'{-96, 64, 0, 10}, '{32, 64, 0, 20}, '{0, 64, -1, 30}};
    e = '{-64, 192, -1, 60};
    run_a(0);
    e = '{0, 192, 0, 60};
    run_a(1);
    // saturation: 9.0 -> 511, -9.0 -> -512, in-range sums unchanged
    v = '{'{192, -192, 100, -100}, '{192, -192, 100, -100}, '{192, -192, 100, -100}};
    e = '{511, -512, 300, -300};
    run_a(0);
    // backpressure after the first final-pass result
    v = '{'{16, 32, 48, 64}, '{16, 32, 48, 64}, '{16, 32, 48, 64}};
    e = '{48, 96, 144, 192};
    pulse_start(0, 0);
    send_pass(0);
    send_pass(1);
    for (int i = 0; i < 4; i++) qa.push_back(e[i]);
    send(0, v[2][0]);
    a_or = 1'b0;
    a_iv = 1'b1;
    a_id = 10'(v[2][1]);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", a_ir, 0);
      chk("bp_out_valid", a_ov, 1);
      chk("bp_out_stable", a_od, 48);
    end
    @(posedge clk); #1;
    a_or = 1'b1;
    send(0, v[2][1]);
    send(0, v[2][2]);
    send(0, v[2][3]);
    @(negedge clk);
    chk("bp_last_latency", a_od, 192);
    @(posedge clk); #1;
    wait_done(0);
    // start mid-ACCUM with relu requested is ignored
    v = '{'{-16, -16, -16, -16}, '{-16, -16, -16, -16}, '{-16, -16, -16, -16}};
    e = '{-48, -48, -48, -48};
    pulse_start(0, 0);
    send_pass(0);
    send(0, v[1][0]);
    send(0, v[1][1]);
    a_start = 1'b1;
    a_relu = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    a_relu = 1'b0;
    @(negedge clk);
    chk("ignored_start_busy", a_busy, 1);
    chk("ignored_start_in_ready", a_ir, 1);
    @(posedge clk); #1;
    send(0, v[1][2]);
    send(0, v[1][3]);
    for (int i = 0; i < 4; i++) qa.push_back(e[i]);
    send_pass(2);
    wait_done(0);
    // reset mid pass 1, then a fresh tile
    v = '{'{32, 32, 32, 32}, '{32, 32, 32, 32}, '{32, 32, 32, 32}};
    e = '{96, 96, 96, 96};
    pulse_start(0, 1);
    send_pass(0);
    send(0, v[1][0]);
    send(0, v[1][1]);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_a(0);
    // single pass, two pixels: values pass straight through, 1-cycle latency
    pulse_start(1, 0);
    qb.push_back(511);
    qb.push_back(-512);
    send(1, 511);
    @(negedge clk);
    chk("b_latency_valid", b_ov, 1);
    chk("b_latency_data", b_od, 511);
    @(posedge clk); #1;
    send(1, -512);
    wait_done(1);
    pulse_start(1, 1);
    qb.push_back(511);
    qb.push_back(0);
    send(1, 511);
    send(1, -512);
    wait_done(1);
    repeat (5) @(negedge clk);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
